// File: rtl/sprite_compositor.sv
// rtl/sprite_compositor.sv - multi-sprite compositor: bouncing sprites over an animated background, 3-cycle pixel pipeline
module sprite_compositor #(
  parameter int NUM_SPRITES = 2,
  parameter int SPRITE_SIZE = 64,
  parameter int H_DISPLAY   = 640,
  parameter int V_DISPLAY   = 480,
  parameter int CB          = 2,
  parameter int STEP        = 1,
  parameter int AW          = 2 * $clog2(SPRITE_SIZE)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          frame_tick,
  input  logic [9:0]                    hpos,
  input  logic [9:0]                    vpos,
  input  logic                          visible,
  input  logic [2:0]                    bg_mode,
  input  logic [3*CB-1:0]               bg_color,
  input  logic [NUM_SPRITES-1:0]        sprite_en,
  output logic [NUM_SPRITES*AW-1:0]     rom_addr,
  input  logic [NUM_SPRITES*3*CB-1:0]   rom_data,
  output logic [CB-1:0]                 R,
  output logic [CB-1:0]                 G,
  output logic [CB-1:0]                 B,
  output logic [3:0]                    bounce_count
);
  localparam int          LW      = $clog2(SPRITE_SIZE);
  localparam int          SW      = 10 + LW;
  localparam int          PW      = 3 * CB;
  localparam logic [9:0]  X_LIMIT = 10'(H_DISPLAY - SPRITE_SIZE);
  localparam logic [9:0]  Y_LIMIT = 10'(V_DISPLAY - SPRITE_SIZE);
  localparam logic [9:0]  STEP_V  = 10'(STEP);
  localparam logic [9:0]  SIZE_V  = 10'(SPRITE_SIZE);

  logic [9:0]                left_q [NUM_SPRITES];
  logic [9:0]                left_d [NUM_SPRITES];
  logic [9:0]                top_q  [NUM_SPRITES];
  logic [9:0]                top_d  [NUM_SPRITES];
  logic [NUM_SPRITES-1:0]    xdir_q, xdir_d, ydir_q, ydir_d;
  logic [3:0]                bounce_q, bounce_d;
  logic [9:0]                sc_q, sc_d;
  logic [NUM_SPRITES*AW-1:0] addr_q, addr_d;
  logic [NUM_SPRITES-1:0]    hit1_q, hit1_d, hit2_q, hit2_d;
  logic [PW-1:0]             bg1_q, bg1_d, bg2_q, bg2_d;
  logic                      vis1_q, vis1_d, vis2_q, vis2_d;
  logic [PW-1:0]             rgb_q, rgb_d;

  logic [9:0] dx [NUM_SPRITES];
  logic [9:0] dy [NUM_SPRITES];
  logic [9:0] hx, vy;
  logic [3:0] bounces;

  // Channel c takes its MSB from src[5+c]; the remaining bits repeat lsb.
  function automatic logic [PW-1:0] stripes(input logic [9:0] src, input logic lsb);
    logic [PW-1:0] s;
    for (int c = 0; c < 3; c++)
      for (int b = 0; b < CB; b++)
        s[c*CB+b] = (b == CB - 1) ? src[5+c] : lsb;
    return s;
  endfunction

  always_comb begin
    left_d   = left_q;
    top_d    = top_q;
    xdir_d   = xdir_q;
    ydir_d   = ydir_q;
    sc_d     = sc_q;
    bounces  = 4'd0;
    if (frame_tick) begin
      sc_d = sc_q + 10'd1;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        if (xdir_q[i]) begin
          if (left_q[i] + STEP_V >= X_LIMIT) begin
            left_d[i] = X_LIMIT; xdir_d[i] = 1'b0; bounces = bounces + 4'd1;
          end else left_d[i] = left_q[i] + STEP_V;
        end else begin
          if (left_q[i] <= STEP_V) begin
            left_d[i] = 10'd0; xdir_d[i] = 1'b1; bounces = bounces + 4'd1;
          end else left_d[i] = left_q[i] - STEP_V;
        end
        if (ydir_q[i]) begin
          if (top_q[i] + STEP_V >= Y_LIMIT) begin
            top_d[i] = Y_LIMIT; ydir_d[i] = 1'b0; bounces = bounces + 4'd1;
          end else top_d[i] = top_q[i] + STEP_V;
        end else begin
          if (top_q[i] <= STEP_V) begin
            top_d[i] = 10'd0; ydir_d[i] = 1'b1; bounces = bounces + 4'd1;
          end else top_d[i] = top_q[i] - STEP_V;
        end
      end
    end
    bounce_d = bounce_q + bounces;

    // Stage 1: sprite-relative coordinates use the positions before any same-edge motion update.
    for (int i = 0; i < NUM_SPRITES; i++) begin
      dx[i] = hpos - left_q[i];
      dy[i] = vpos - top_q[i];
      hit1_d[i] = sprite_en[i] && (dx[i] < SIZE_V) && (dy[i] < SIZE_V);
      addr_d[i*AW +: AW] = AW'({dy[i], {LW{1'b0}}} + SW'(dx[i]));
    end
    hx = hpos + sc_q;
    vy = vpos + sc_q;
    case (bg_mode)
      3'd0:    bg1_d = bg_color;
      3'd1:    bg1_d = stripes(hpos, vpos[1]);
      3'd2:    bg1_d = stripes(vpos, hpos[1]);
      3'd3:    bg1_d = stripes(hx, vpos[1]);
      3'd4:    bg1_d = stripes(vy, hx[2]);
      3'd5:    bg1_d = {PW{hpos[5] ^ vpos[5]}};
      default: bg1_d = '0;
    endcase
    vis1_d = visible;

    hit2_d = hit1_q;
    bg2_d  = bg1_q;
    vis2_d = vis1_q;

    // Stage 3: scan high to low so the lowest opaque index is the last to claim the pixel.
    rgb_d = bg2_q;
    for (int i = NUM_SPRITES - 1; i >= 0; i--)
      if (hit2_q[i] && (rom_data[i*PW +: PW] != '0))
        rgb_d = rom_data[i*PW +: PW];
    if (!vis2_q) rgb_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        left_q[i] <= 10'(32 + 96 * i);
        top_q[i]  <= 10'(32 + 64 * i);
      end
      xdir_q   <= '1;
      ydir_q   <= '1;
      bounce_q <= 4'd0;
      sc_q     <= 10'd0;
      addr_q   <= '0;
      hit1_q   <= '0;
      hit2_q   <= '0;
      bg1_q    <= '0;
      bg2_q    <= '0;
      vis1_q   <= 1'b0;
      vis2_q   <= 1'b0;
      rgb_q    <= '0;
    end else begin
      left_q   <= left_d;
      top_q    <= top_d;
      xdir_q   <= xdir_d;
      ydir_q   <= ydir_d;
      bounce_q <= bounce_d;
      sc_q     <= sc_d;
      addr_q   <= addr_d;
      hit1_q   <= hit1_d;
      hit2_q   <= hit2_d;
      bg1_q    <= bg1_d;
      bg2_q    <= bg2_d;
      vis1_q   <= vis1_d;
      vis2_q   <= vis2_d;
      rgb_q    <= rgb_d;
    end
  end

  assign rom_addr     = addr_q;
  assign {R, G, B}    = rgb_q;
  assign bounce_count = bounce_q;
endmodule

// File: tb/tb_sprite_compositor.sv
// tb/tb_sprite_compositor.sv - randomized self-checking bench for sprite_compositor against a frame-level model
module tb_sprite_compositor;
  localparam int NS = 2;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst, frame_tick, visible;
  logic [9:0]    hpos, vpos;
  logic [2:0]    bg_mode;
  logic [5:0]    bg_color;
  logic [1:0]    sprite_en;
  logic [23:0]   rom_addr;
  logic [11:0]   rom_data;
  logic [1:0]    R, G, B;
  logic [3:0]    bounce_count;

  sprite_compositor dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .hpos(hpos), .vpos(vpos),
    .visible(visible), .bg_mode(bg_mode), .bg_color(bg_color), .sprite_en(sprite_en),
    .rom_addr(rom_addr), .rom_data(rom_data), .R(R), .G(G), .B(B),
    .bounce_count(bounce_count)
  );

  always #5 clk = ~clk;

  logic [5:0] rom_mem [NS][4096];
  always @(posedge clk)
    for (int i = 0; i < NS; i++) rom_data[i*6 +: 6] <= rom_mem[i][rom_addr[i*12 +: 12]];

  int n_vec = 0;
  int n_bad = 0;
  int m_left[NS], m_top[NS], m_xd[NS], m_yd[NS];
  int m_bc, m_sc;
  bit m_valid = 0;
  logic [5:0]  exp_q[$];
  logic [23:0] exp_addr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] stripe_ref(int src, int lsb);
    int r = 0;
    for (int c = 0; c < 3; c++) r += (2 * ((src >> (5 + c)) & 1) + lsb) << (2 * c);
    return 6'(r);
  endfunction

  function automatic logic [5:0] bg_ref(int mode, int h, int v, int sc, logic [5:0] col);
    int hx = (h + sc) % 1024;
    int vy = (v + sc) % 1024;
    case (mode)
      0: return col;
      1: return stripe_ref(h, (v >> 1) & 1);
      2: return stripe_ref(v, (h >> 1) & 1);
      3: return stripe_ref(hx, (v >> 1) & 1);
      4: return stripe_ref(vy, (hx >> 2) & 1);
      5: return (((h >> 5) ^ (v >> 5)) & 1) != 0 ? 6'h3f : 6'h00;
      default: return 6'h00;
    endcase
  endfunction

  function automatic logic [5:0] pix_ref(int h, int v, logic vis, int mode, logic [5:0] col, logic [1:0] en);
    if (!vis) return 6'h00;
    for (int i = 0; i < NS; i++) begin
      int dx = h - m_left[i];
      int dy = v - m_top[i];
      if (en[i] && dx >= 0 && dx < 64 && dy >= 0 && dy < 64 && rom_mem[i][dy*64+dx] != 0)
        return rom_mem[i][dy*64+dx];
    end
    return bg_ref(mode, h, v, m_sc, col);
  endfunction

  function automatic logic [23:0] addr_ref(int h, int v);
    logic [23:0] a = '0;
    for (int i = 0; i < NS; i++)
      a[i*12 +: 12] = 12'(((((v - m_top[i]) & 1023) * 64) + ((h - m_left[i]) & 1023)) & 4095);
    return a;
  endfunction

  task automatic axis(inout int pos, inout int dir, input int lim, inout int nb);
    if (dir == 1) begin
      if (pos + 1 >= lim) begin pos = lim; dir = 0; nb++; end
      else pos = pos + 1;
    end else begin
      if (pos <= 1) begin pos = 0; dir = 1; nb++; end
      else pos = pos - 1;
    end
  endtask

  task automatic model_tick();
    int nb = 0;
    for (int i = 0; i < NS; i++) begin
      int p = m_left[i];
      int d = m_xd[i];
      axis(p, d, 576, nb);
      m_left[i] = p; m_xd[i] = d;
      p = m_top[i]; d = m_yd[i];
      axis(p, d, 416, nb);
      m_top[i] = p; m_yd[i] = d;
    end
    m_bc = (m_bc + nb) % 16;
    m_sc = (m_sc + 1) % 1024;
  endtask

  // One pixel clock: check what the previous edges produced, then apply and model this cycle's inputs.
  task automatic drive(input logic r, input int h, input int v, input logic vis, input int mode,
                       input logic [5:0] col, input logic [1:0] en, input logic tick);
    if (m_valid) begin
      check("bounce_count", 32'(bounce_count), 32'(m_bc));
      check("rom_addr", 32'(rom_addr), 32'(exp_addr));
    end
    if (exp_q.size() == 3) check("rgb", 32'({R, G, B}), 32'(exp_q.pop_front()));
    rst = r; hpos = 10'(h); vpos = 10'(v); visible = vis; bg_mode = 3'(mode);
    bg_color = col; sprite_en = en; frame_tick = tick;
    if (r) begin
      foreach (exp_q[j]) exp_q[j] = 6'h00;
      exp_q.push_back(6'h00);
      exp_addr = '0;
      for (int i = 0; i < NS; i++) begin
        m_left[i] = 32 + 96 * i; m_top[i] = 32 + 64 * i; m_xd[i] = 1; m_yd[i] = 1;
      end
      m_bc = 0; m_sc = 0; m_valid = 1;
    end else begin
      exp_q.push_back(pix_ref(h & 1023, v & 1023, vis, mode, col, en));
      exp_addr = addr_ref(h & 1023, v & 1023);
      if (tick) model_tick();
    end
    @(posedge clk); #1;
  endtask

  task automatic flush();
    repeat (3) drive(0, 1000, 1000, 0, 0, 6'h00, 2'b11, 0);
  endtask

  initial begin
    int h, v, s, vv, a0, a1;
    bit prio_done = 0;
    for (int i = 0; i < NS; i++)
      for (int a = 0; a < 4096; a++)
        rom_mem[i][a] = ($urandom_range(3) == 0) ? 6'h00 : 6'($urandom_range(63, 1));
    rst = 1; frame_tick = 0; hpos = 0; vpos = 0; visible = 0; bg_mode = 0; bg_color = 0; sprite_en = 0;
    @(posedge clk); #1;

    drive(1, 0, 0, 1, 0, 6'b101010, 2'b00, 0);
    drive(1, 0, 0, 1, 0, 6'b101010, 2'b00, 0);
    repeat (6) drive(0, 100, 100, 1, 0, 6'b101010, 2'b00, 0);

    rom_mem[0][200] = 6'b110000;
    drive(0, 40, 35, 1, 0, 6'b101010, 2'b01, 0);
    drive(0, 40, 35, 0, 0, 6'b101010, 2'b01, 0);
    flush();

    for (int t = 0; t < 4600; t++) begin
      s = $urandom_range(NS - 1);
      if ($urandom_range(1)) begin
        h = m_left[s] + $urandom_range(79) - 8;
        v = m_top[s] + $urandom_range(79) - 8;
      end else begin
        h = $urandom_range(799);
        v = $urandom_range(524);
      end
      drive(0, h, v, $urandom_range(7) != 0, $urandom_range(7), 6'($urandom),
            2'($urandom), 1);
      if (!prio_done && (m_left[0] - m_left[1]) < 64 && (m_left[1] - m_left[0]) < 64 &&
          (m_top[0] - m_top[1]) < 64 && (m_top[1] - m_top[0]) < 64) begin
        prio_done = 1;
        h = (m_left[0] > m_left[1]) ? m_left[0] : m_left[1];
        v = (m_top[0] > m_top[1]) ? m_top[0] : m_top[1];
        a0 = (v - m_top[0]) * 64 + (h - m_left[0]);
        a1 = (v - m_top[1]) * 64 + (h - m_left[1]);
        flush();
        rom_mem[0][a0] = 6'b000011; rom_mem[1][a1] = 6'b101101;
        drive(0, h, v, 1, 0, 6'b010101, 2'b11, 0);
        flush();
        rom_mem[0][a0] = 6'b000000;
        drive(0, h, v, 1, 0, 6'b010101, 2'b11, 0);
        flush();
        rom_mem[1][a1] = 6'b000000;
        drive(0, h, v, 1, 0, 6'b010101, 2'b11, 0);
        flush();
      end
    end
    if (!prio_done) begin
      n_vec++; n_bad++;
      $error("FAIL overlap_search observed=none expected=overlap");
    end

    drive(1, 0, 0, 1, 3, 6'h00, 2'b00, 0);
    repeat (32) drive(0, 0, 0, 1, 3, 6'h00, 2'b00, 1);
    vv = $urandom_range(479);
    repeat (4) drive(0, 0, vv, 1, 3, 6'h00, 2'b00, 0);
    check("scroll_vs_mode1", 32'({R, G, B}), 32'(bg_ref(1, 32, vv, 0, 6'h00)));
    repeat (4) drive(0, 5, 5, 1, 5, 6'h00, 2'b00, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/sprite_compositor.md
Name: sprite_compositor

Overview:
- Parametrised successor to the single-sprite pixel colour stage.
- Composites NUM_SPRITES independently bouncing sprites over a selectable animated background.
- Drives one address bus per sprite to external synchronous sprite ROMs.
- Supports colour-key transparency and fixed index priority; outputs registered RGB with fixed pipeline latency to the VGA output stage.

Parameters:
- NUM_SPRITES, 2, number of sprites (1..4).
- SPRITE_SIZE, 64, sprite edge in pixels, power of 2.
- H_DISPLAY, 640, visible width.
- V_DISPLAY, 480, visible height.
- CB, 2, bits per colour channel.
- STEP, 1, pixels moved per frame per axis.
- AW, 2*log2(SPRITE_SIZE), ROM address width, derived.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse, once per frame, during vertical blank.
- hpos  in  10  current pixel x.
- vpos  in  10  current pixel y.
- visible  in  1  pixel is in the active area.
- bg_mode  in  3  background select.
- bg_color  in  3*CB  solid background colour {R,G,B}.
- sprite_en  in  NUM_SPRITES  per-sprite enable.
- rom_addr  out  NUM_SPRITES*AW  per-sprite ROM address; sprite i occupies slice i.
- rom_data  in  NUM_SPRITES*3*CB  per-sprite ROM colour, valid one cycle after rom_addr.
- R  out  CB  red.
- G  out  CB  green.
- B  out  CB  blue.
- bounce_count  out  4  wall-bounce event counter.

Behaviour:
- Reset:
  - R, G, B, rom_addr, bounce_count and scroll counter = 0. Pipeline valid/hit flags = 0.
  - sprite i: left = 32+96*i, top = 32+64*i, xdir = +, ydir = +.
  - Parameters must keep all reset positions inside the display.
- Reset mid-frame takes effect on the next edge. No partial pixel is emitted; the output is 0 for 3 cycles after reset is released.
- Pipeline: hpos/vpos/visible sampled at edge k produce R/G/B after edge k+3.
  - Stage 1 (edge k+1):
    - dx_i = hpos-left_i, dy_i = vpos-top_i, computed mod 2^10.
    - hit_i = sprite_en[i] and dx_i < SPRITE_SIZE and dy_i < SPRITE_SIZE, with no sign wrap accepted.
    - rom_addr_i = dy_i*SPRITE_SIZE + dx_i, truncated to AW bits. rom_addr is registered.
    - Background colour computed and registered.
  - Stage 2 (edge k+2): external ROM returns data; hit flags, background and visible are delayed to match.
  - Stage 3 (edge k+3): output registered.
    - Winner = lowest index i with hit_i and rom_data_i != 0. All-zero rom_data is transparent.
    - If no winner, output background. If the delayed visible = 0, output 0.
- Background (uses stage-1 hpos/vpos and scroll counter sc, 10 bits; sc increments on frame_tick, wraps at 1023):
  - 0: bg_color.
  - 1: vertical stripes, channel c MSB = hpos[5+c], LSBs = vpos[1].
  - 2: horizontal stripes, channel c MSB = vpos[5+c], LSBs = hpos[1].
  - 3: x-scroll, as mode 1 with hpos+sc.
  - 4: diagonal scroll, as mode 2 with vpos+sc and LSBs = (hpos+sc)[2].
  - 5: checkerboard, all channels = {CB{hpos[5]^vpos[5]}}.
  - 6, 7: black.
  - For CB=2, c = 0,1,2 selects B,G,R respectively.
- Motion: updated only on frame_tick; positions are constant otherwise. Per axis, per sprite, including disabled sprites:
  - + direction: if pos+STEP >= LIMIT, then pos = LIMIT and direction becomes -. Else pos += STEP.
  - - direction: if pos <= STEP, then pos = 0 and direction becomes +. Else pos -= STEP.
  - LIMIT = H_DISPLAY-SPRITE_SIZE for x, V_DISPLAY-SPRITE_SIZE for y.
  - Each axis reversal of each sprite in the same tick counts once. bounce_count increases by the total count (0..2*NUM_SPRITES), mod 16.
- A frame_tick during active pixels is legal. Pixels sampled before the update edge use the old positions.

Test Plan:
- Reset pixel path: rst for 2 cycles, then hold visible=1, bg_mode=0, bg_color=6'b101010, sprites disabled -> RGB=0 for 3 cycles, then 6'b101010 every cycle.
- Latency: sprite0 enabled at (32,32); drive hpos=40, vpos=35 at edge k -> rom_addr slice0 = 3*64+8 = 200 after edge k+1; ROM returns 6'b110000 -> RGB=6'b110000 after edge k+3.
- Priority and transparency: pixel where both sprites hit -> sprite0 data 6'b000011 wins over sprite1. Sprite0 data 0 -> sprite1 colour. Both 0 -> background.
- Bounce: force sprite0 to left=575, xdir + via ticks -> after next tick left=576, xdir -, bounce_count+1. Next tick left=575. A corner hit on both axes in one tick -> bounce_count+2.
- Visible gating: visible=0 at edge k with sprite hit -> RGB=0 after edge k+3.
- Scroll: bg_mode=3, 32 frame_ticks -> the colour at hpos=0 equals the mode-1 colour at hpos=32.
